// File: rtl/pulse_event_queue_if.sv
// Consumer-side bundle for pulse_event_queue: the valid/ready event
// handshake plus the registered pending-event count.
// master = the queue (drives valid/pending), slave = the consumer.
interface pulse_event_queue_if #(
    parameter int CNT_W = 4
);
    logic             event_valid;
    logic             event_ready;
    logic [CNT_W-1:0] pending;

    modport master (
        output event_valid,
        output pending,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  pending,
        output event_ready
    );
endinterface

// File: rtl/pulse_event_queue.sv
// pulse_event_queue: counts single-cycle event pulses and presents them one at
// a time on a valid/ready handshake, with an optional holdoff gap after each
// accepted event. The counter saturates at 2^CNT_W-1; extra pulses are dropped.
// Build option: define PULSE_EVENT_QUEUE_OVF_EN to get the sticky overflow flag
// (set on a dropped event, cleared by ovf_clr). Without it overflow reads 0.
module pulse_event_queue #(
    parameter int CNT_W   = 4,
    parameter int HOLDOFF = 8
) (
    input  logic                       clk_dst,
    input  logic                       reset_n,
    input  logic                       pulse_in,
    input  logic                       ovf_clr,
    output logic                       overflow,
    pulse_event_queue_if.master        evt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Timer counts down from HOLDOFF-1 to 0; the edge that sees 0 ends the
    // holdoff, which gives exactly HOLDOFF low cycles after the accept edge.
    localparam int TMR_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = (HOLDOFF > 0) ? TMR_W'(HOLDOFF - 1) : '0;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] pending_d;
    logic             event_valid_q;
    logic             accept;
    logic             pend_inc;
    logic             pend_dec;

    // event_valid is only ever high in VALID, so this is the handshake fire
    assign accept   = event_valid_q & evt.event_ready;
    // a pulse with a simultaneous accept is a net no-op, even at saturation
    assign pend_inc = pulse_in & ~accept & (pending_q != PEND_MAX);
    assign pend_dec = accept & ~pulse_in;

    // next pending count: saturating at max, never below zero
    always_comb begin
        pending_d = pending_q;
        if (pend_inc) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (pend_dec && (pending_q != '0)) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    // presentation FSM with registered valid, holdoff timer and pending counter
    always_ff @(posedge clk_dst or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            pending_q     <= '0;
            event_valid_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (pending_d != '0) begin
                        state_q       <= VALID;
                        event_valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (accept) begin
                        if (HOLDOFF > 0) begin
                            state_q       <= HOLD;
                            timer_q       <= TMR_LOAD;
                            event_valid_q <= 1'b0;
                        end else if (pending_d == '0) begin
                            state_q       <= IDLE;
                            event_valid_q <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (timer_q == '0) begin
                        // pulses arriving on the expiry edge count immediately
                        if (pending_d != '0) begin
                            state_q       <= VALID;
                            event_valid_q <= 1'b1;
                        end else begin
                            state_q       <= IDLE;
                            event_valid_q <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    timer_q       <= '0;
                    event_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PULSE_EVENT_QUEUE_OVF_EN
    logic overflow_q;
    logic drop;

    // a pulse is lost only when the counter is full and nothing is leaving
    assign drop = pulse_in & ~accept & (pending_q == PEND_MAX);

    // sticky overflow: a new drop wins over a simultaneous clear
    always_ff @(posedge clk_dst or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow = overflow_q;
`else
    // overflow reporting compiled out: drops still happen, silently
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

    assign evt.event_valid = event_valid_q;
    assign evt.pending     = pending_q;

endmodule

// File: doc/pulse_event_queue.md
PULSE_EVENT_QUEUE -- requirements
Module: pulse_event_queue

Interface
REQ-001 Parameter CNT_W, default 4: width of the pending-event counter; capacity is 2^CNT_W-1 events.
REQ-002 Parameter HOLDOFF, default 8: cycles event_valid is forced low after each accepted event; 0 disables holdoff.
REQ-003 clk_dst  input  1  destination clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 pulse_in  input  1  synchronized single-cycle event pulse from the synchronizer stage; each sampled-high cycle is one event.
REQ-006 event_ready  input  1  consumer accepts the presented event.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 event_valid  output  1  at least one event is pending and presentable.
REQ-009 pending  output  CNT_W  current pending-event count, registered.
REQ-010 overflow  output  1  sticky flag: an event was dropped at saturation.

Function
REQ-011 Handshake: an event is accepted on a rising edge where event_valid=1 and event_ready=1; event_ready is ignored when event_valid=0.
REQ-012 Once asserted, event_valid stays high until accepted; no withdrawal.
REQ-013 pending update per edge: +1 on pulse_in only; -1 on accept only; unchanged on pulse_in with accept in the same cycle.
REQ-014 Saturation: pulse_in with pending=2^CNT_W-1 and no accept leaves pending unchanged, drops the event, and sets overflow.
REQ-015 A pulse at saturation coinciding with an accept is not a drop: pending stays at max and overflow is unchanged.
REQ-016 pending never wraps: no decrement below 0, no increment above max.
REQ-017 FSM states: IDLE (valid=0), VALID (valid=1), HOLD (valid=0, holdoff timer running).
REQ-018 IDLE->VALID on the edge where next pending is nonzero; latency is one edge, so pulse_in high at edge N gives event_valid=1 and pending=1 after edge N.
REQ-019 VALID on accept with HOLDOFF>0: go to HOLD and load the timer so event_valid is low for exactly HOLDOFF cycles.
REQ-020 VALID on accept with HOLDOFF=0: stay in VALID if next pending is nonzero, else go to IDLE.
REQ-021 HOLD: timer decrements each edge; at expiry go to VALID if pending is nonzero, else IDLE.
REQ-022 pulse_in is counted in every state, including HOLD.
REQ-023 overflow clears on the edge where ovf_clr=1; a simultaneous new drop takes priority and overflow stays 1.

Reset
REQ-024 reset_n low asynchronously forces state=IDLE, pending=0, timer=0, overflow=0, event_valid=0.
REQ-025 Reset mid-HOLD or with events pending discards all of them; after release, operation resumes from IDLE on the first edge.

Configuration
REQ-026 Macro PULSE_EVENT_QUEUE_OVF_EN defined: overflow and ovf_clr behave as in REQ-014 and REQ-023.
REQ-027 Macro PULSE_EVENT_QUEUE_OVF_EN undefined: overflow is tied to 0, ovf_clr is ignored, and drops at saturation still occur silently; all other behaviour is identical.

Verification
REQ-028 Single pulse, event_ready=1, HOLDOFF=8 -> event_valid high for one cycle one edge after the pulse, then low for 8 cycles; pending goes 1 then 0.
REQ-029 Three pulses on consecutive cycles, event_ready=0 -> pending=3; then event_ready=1 -> three accepts, each separated by 8 holdoff cycles; pending goes 3->2->1->0.
REQ-030 CNT_W=4: 16 pulses with event_ready=0 -> pending=15, overflow=1; ovf_clr pulse -> overflow=0 and pending stays 15.
REQ-031 pending=15 with pulse_in and accept in the same cycle -> pending=15 and overflow stays 0.
REQ-032 Two pulses during HOLD -> pending=2 at timer expiry and event_valid=1 on the expiry edge.
REQ-033 reset_n low for 1 cycle while in HOLD with pending=5 -> outputs 0 immediately; a new pulse after release gives event_valid one edge later.
